multicycle_control: RTL
=======================

# multicycle_control

Finite-state controller that sequences the shared multicycle MIPS datapath: one ALU, one unified instruction/data memory, the register file, and the IR/PC registers. It decodes the IR opcode and steps each instruction through fetch, decode, execute, memory and write-back, one datapath stage per cycle. Each memory access waits on a ready handshake from the memory. It drives every datapath enable and mux select; the existing ALU-control block consumes `aluop`.

## Interface
- No parameters.
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-low reset (0 = in reset).
- `opcode`  in  6  IR[31:26]; stable outside FETCH.
- `mem_ready`  in  1  memory has completed the current read/write this cycle.
- `pcwrite`, `pcwritecond`, `irwrite`, `regwrite`  out  1 each  register write enables.
- `memread`, `memwrite`, `iord`  out  1 each  memory strobes; `iord` 0 = PC address, 1 = ALUOut.
- `memtoreg`, `regdst`, `alusrca`  out  1 each  mux selects.
- `alusrcb`  out  2  00 = B, 01 = constant 4, 10 = sign-extended imm, 11 = imm<<2.
- `aluop`  out  2  00 = add, 01 = sub, 10 = funct field.
- `pcsource`  out  2  00 = ALU result, 01 = ALUOut, 10 = jump target.
- `instr_done`  out  1  final cycle of an instruction.
- `illegal_op`  out  1  unknown opcode seen in DECODE.
- `state`  out  4  current state, for debug.

## Operation
- Decoded opcodes: 000000 R-type, 100011 lw, 101011 sw, 000100 beq, 000010 j, 001000 addi. Any other opcode is illegal.
- State encoding: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, ALUWB=7, BRANCH=8, JUMP=9, ADDIEX=10, ADDIWB=11. Codes 12–15 return to FETCH.
- Default for every output is 0 in every state. Only the non-zero outputs are listed below.
- FETCH: `memread`=1, `alusrcb`=01. `irwrite`=`pcwrite`=`mem_ready`; this is the only Mealy gating besides MEMWR.
  - Stay in FETCH while `mem_ready`=0; go to DECODE when it is 1.
- DECODE: `alusrcb`=11 to precompute the branch target.
  - Next state: lw/sw→MEMADR, R→EXEC, beq→BRANCH, j→JUMP, addi→ADDIEX.
  - Illegal opcode: `illegal_op`=1 for this cycle, next state FETCH.
- MEMADR: `alusrca`=1, `alusrcb`=10. Next state: lw→MEMRD, sw→MEMWR.
- MEMRD: `memread`=1, `iord`=1. Hold while `mem_ready`=0; go to MEMWB when it is 1.
- MEMWB: `memtoreg`=1, `regwrite`=1, `regdst`=0, `instr_done`=1. Next state FETCH.
- MEMWR: `memwrite`=1, `iord`=1. Hold while `mem_ready`=0.
  - On the cycle `mem_ready`=1: `instr_done`=1, next state FETCH.
- EXEC: `alusrca`=1, `aluop`=10. Next state ALUWB.
- ALUWB: `regdst`=1, `regwrite`=1, `instr_done`=1. Next state FETCH.
- BRANCH: `alusrca`=1, `aluop`=01, `pcwritecond`=1, `pcsource`=01, `instr_done`=1. Next state FETCH.
- JUMP: `pcwrite`=1, `pcsource`=10, `instr_done`=1. Next state FETCH.
- ADDIEX: `alusrca`=1, `alusrcb`=10. Next state ADDIWB.
- ADDIWB: `regwrite`=1, `regdst`=0, `instr_done`=1. Next state FETCH.
- `mem_ready` is ignored in every state that does not access memory.

## Timing
- State is a single registered vector; all outputs decode combinationally from state, `opcode` and `mem_ready`.
- Reset assertion (`reset`=0): state is forced to FETCH immediately, without waiting for a clock edge.
  - While `reset`=0, every output is forced to 0, including `memread`, `pcwrite`, `irwrite`, `regwrite` and `memwrite`. `state` reads 0.
- Reset release: FETCH outputs appear in the same cycle. The first state transition happens on the first rising edge at which `mem_ready`=1.
- Reset asserted mid-instruction aborts it. No write enable may be asserted after the falling edge of `reset`.
- Cycle counts with zero-wait memory (`mem_ready` tied to 1):
  - R-type 4, lw 5, sw 4, beq 3, j 3, addi 4, illegal 2.
  - Each cycle of `mem_ready`=0 in FETCH, MEMRD or MEMWR adds exactly one cycle.
- `instr_done` is high for exactly one cycle per completed instruction. It is never high in the same cycle as `illegal_op`.

## Test plan
- Reset: hold `reset`=0 for 3 cycles mid-EXEC → `state`=0 immediately, all outputs 0. After release, `memread`=1 and `alusrcb`=01.
- Zero-wait sequence R, lw, sw, beq, j, addi, with `mem_ready`=1 → `instr_done` pulses at cycles 4, 9, 13, 16, 19 and 23. `regwrite`=1 only in ALUWB, MEMWB and ADDIWB.
- Wait states: lw with `mem_ready` low for 2 cycles in FETCH and 3 in MEMRD → 10 cycles total. `irwrite` is asserted for only 1 cycle, `regwrite` for only 1 cycle.
- sw with 1 wait in MEMWR → `memwrite` high for 2 cycles; `instr_done` coincides with the `mem_ready`=1 cycle.
- Illegal opcode 111111 → `illegal_op`=1 in DECODE, then FETCH. No write enable is asserted.
- Branch/jump selects: BRANCH drives `pcwritecond`=1, `pcsource`=01, `aluop`=01. JUMP drives `pcwrite`=1, `pcsource`=10. `pcwritecond`=0 in every other state.

Source files
------------

// File: rtl/multicycle_control.sv
// -----------------------------------------------------------------------------
// multicycle_control
//
// Main controller for the shared multicycle MIPS datapath. It decodes the IR
// opcode and moves each instruction through fetch, decode, execute, memory and
// write-back, one datapath stage per cycle. Memory stages wait on mem_ready.
//
// Ports
//   clk          rising-edge clock
//   reset        asynchronous, active-low reset (0 = in reset)
//   opcode[5:0]  IR[31:26]; stable outside FETCH
//   mem_ready    memory completes the current read/write this cycle
//   pcwrite, pcwritecond, irwrite, regwrite   register write enables
//   memread, memwrite, iord                   memory strobes (iord: 0 PC, 1 ALUOut)
//   memtoreg, regdst, alusrca                 mux selects
//   alusrcb[1:0] 00 B, 01 const 4, 10 sign-ext imm, 11 imm<<2
//   aluop[1:0]   00 add, 01 sub, 10 funct field
//   pcsource[1:0] 00 ALU result, 01 ALUOut, 10 jump target
//   instr_done   final cycle of an instruction
//   illegal_op   unknown opcode seen in DECODE
//   state[3:0]   current state, for debug
// -----------------------------------------------------------------------------
module multicycle_control (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic       mem_ready,
  output logic       pcwrite,
  output logic       pcwritecond,
  output logic       irwrite,
  output logic       regwrite,
  output logic       memread,
  output logic       memwrite,
  output logic       iord,
  output logic       memtoreg,
  output logic       regdst,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] aluop,
  output logic [1:0] pcsource,
  output logic       instr_done,
  output logic       illegal_op,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,
    S_JUMP   = 4'd9,
    S_ADDIEX = 4'd10,
    S_ADDIWB = 4'd11
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  state_e state_q, state_d;
  logic   op_legal;

  assign op_legal = (opcode == OP_RTYPE) || (opcode == OP_LW) || (opcode == OP_SW) ||
                    (opcode == OP_BEQ)   || (opcode == OP_J)  || (opcode == OP_ADDI);

  // ---------------------------------------------------------------------------
  // State register. Reset asserts asynchronously so an in-flight instruction is
  // aborted immediately rather than at the next edge.
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignment so every flop samples
  // its inputs from before the edge, independent of process ordering.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= S_FETCH;
    else        state_q <= state_d;
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:  if (mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_EXEC;
          OP_BEQ:       state_d = S_BRANCH;
          OP_J:         state_d = S_JUMP;
          OP_ADDI:      state_d = S_ADDIEX;
          default:      state_d = S_FETCH;   // illegal opcode: abandon and refetch
        endcase
      end
      // Only lw/sw reach MEMADR; anything else falls back to FETCH defensively.
      S_MEMADR: begin
        if (opcode == OP_LW)      state_d = S_MEMRD;
        else if (opcode == OP_SW) state_d = S_MEMWR;
        else                      state_d = S_FETCH;
      end
      S_MEMRD:  if (mem_ready) state_d = S_MEMWB;
      S_MEMWB:  state_d = S_FETCH;
      S_MEMWR:  if (mem_ready) state_d = S_FETCH;
      S_EXEC:   state_d = S_ALUWB;
      S_ALUWB:  state_d = S_FETCH;
      S_BRANCH: state_d = S_FETCH;
      S_JUMP:   state_d = S_FETCH;
      S_ADDIEX: state_d = S_ADDIWB;
      S_ADDIWB: state_d = S_FETCH;
      default:  state_d = S_FETCH;           // unused codes 12-15 recover
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output decode. Everything is forced low while reset is held: state is
  // already FETCH then, but FETCH would otherwise drive memread and, with
  // mem_ready high, irwrite/pcwrite.
  // ---------------------------------------------------------------------------
  // NOTE: every output gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    pcwrite     = 1'b0;
    pcwritecond = 1'b0;
    irwrite     = 1'b0;
    regwrite    = 1'b0;
    memread     = 1'b0;
    memwrite    = 1'b0;
    iord        = 1'b0;
    memtoreg    = 1'b0;
    regdst      = 1'b0;
    alusrca     = 1'b0;
    alusrcb     = 2'b00;
    aluop       = 2'b00;
    pcsource    = 2'b00;
    instr_done  = 1'b0;
    illegal_op  = 1'b0;
    if (reset) begin
      case (state_q)
        S_FETCH: begin
          memread = 1'b1;
          alusrcb = 2'b01;
          // IR and PC+4 commit only on the cycle the instruction word arrives.
          irwrite = mem_ready;
          pcwrite = mem_ready;
        end
        S_DECODE: begin
          alusrcb    = 2'b11;              // precompute branch target
          illegal_op = ~op_legal;
        end
        S_MEMADR: begin
          alusrca = 1'b1;
          alusrcb = 2'b10;
        end
        S_MEMRD: begin
          memread = 1'b1;
          iord    = 1'b1;
        end
        S_MEMWB: begin
          memtoreg   = 1'b1;
          regwrite   = 1'b1;
          instr_done = 1'b1;
        end
        S_MEMWR: begin
          memwrite   = 1'b1;
          iord       = 1'b1;
          instr_done = mem_ready;          // store retires when memory accepts it
        end
        S_EXEC: begin
          alusrca = 1'b1;
          aluop   = 2'b10;
        end
        S_ALUWB: begin
          regdst     = 1'b1;
          regwrite   = 1'b1;
          instr_done = 1'b1;
        end
        S_BRANCH: begin
          alusrca     = 1'b1;
          aluop       = 2'b01;
          pcwritecond = 1'b1;
          pcsource    = 2'b01;
          instr_done  = 1'b1;
        end
        S_JUMP: begin
          pcwrite    = 1'b1;
          pcsource   = 2'b10;
          instr_done = 1'b1;
        end
        S_ADDIEX: begin
          alusrca = 1'b1;
          alusrcb = 2'b10;
        end
        S_ADDIWB: begin
          regwrite   = 1'b1;
          instr_done = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign state = state_q;

endmodule
